// File: rtl/ddr_clock_generator_pkg.sv
// ddr_clk_pkg: channel FSM states, reset-time timing values and a width helper.
package ddr_clk_pkg;
  typedef enum logic [2:0] {IDLE, PH_P, DEAD_PN, PH_N, DEAD_NP} chanState_t;
  localparam int DIV_RST = 2;
  localparam int DEAD_RST = 0;
  function automatic int maxWidth(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ddr_clock_generator_if.sv
// ddr_clock_generator_if: config write bus (CfgValid/CfgReady handshake, CfgChan/CfgDiv/CfgDead payload, CfgError reject pulse).
interface ddr_clock_generator_if #(
  parameter int CHAN_W = 1,
  parameter int DIV_WIDTH = 8,
  parameter int DEAD_WIDTH = 4
);
  logic CfgValid;
  logic CfgReady;
  logic [CHAN_W-1:0] CfgChan;
  logic [DIV_WIDTH-1:0] CfgDiv;
  logic [DEAD_WIDTH-1:0] CfgDead;
  logic CfgError;
  modport master(output CfgValid, CfgChan, CfgDiv, CfgDead, input CfgReady, CfgError);
  modport slave(input CfgValid, CfgChan, CfgDiv, CfgDead, output CfgReady, CfgError);
endinterface

// File: rtl/ddr_clock_generator_channel.sv
// ddr_clock_channel: one non-overlapping clock pair; ports clock/resetN, enable, wrEn/wrDiv/wrDead (validated shadow write), clockP/clockN/running.
module ddr_clock_channel
  import ddr_clk_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int DEAD_WIDTH = 4
) (
  input  logic clock,
  input  logic resetN,
  input  logic enable,
  input  logic wrEn,
  input  logic [DIV_WIDTH-1:0] wrDiv,
  input  logic [DEAD_WIDTH-1:0] wrDead,
  output logic clockP,
  output logic clockN,
  output logic running
);
  localparam int CW = maxWidth(DIV_WIDTH, DEAD_WIDTH);
  chanState_t state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic [DIV_WIDTH-1:0] shDiv, actDiv, newDiv;
  logic [DEAD_WIDTH-1:0] shDead, actDead, newDead;
  logic pending, apply, last, noDead;
  // A write landing in the same cycle as a period start is forwarded so it governs that period.
  always_comb begin
    newDiv = wrEn ? wrDiv : pending ? shDiv : actDiv;
    newDead = wrEn ? wrDead : pending ? shDead : actDead;
    last = cnt == CW'(1);
    noDead = actDead == '0;
    nextState = state;
    apply = 1'b0;
    case (state)
      IDLE: if (enable) begin
        nextState = PH_P;
        apply = 1'b1;
      end
      PH_P: if (last) nextState = noDead ? PH_N : DEAD_PN;
      DEAD_PN: if (last) nextState = PH_N;
      PH_N: if (last) begin
        nextState = !noDead ? DEAD_NP : enable ? PH_P : IDLE;
        apply = noDead && enable;
      end
      DEAD_NP: if (last) begin
        nextState = enable ? PH_P : IDLE;
        apply = enable;
      end
      default: nextState = IDLE;
    endcase
    nextCnt = nextState == state ? cnt - CW'(1) :
              nextState == PH_P ? CW'(newDiv) - CW'(newDead) :
              nextState == PH_N ? CW'(actDiv) - CW'(actDead) :
              nextState == IDLE ? '0 : CW'(actDead);
  end
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state <= IDLE;
      cnt <= '0;
      shDiv <= DIV_WIDTH'(DIV_RST);
      shDead <= DEAD_WIDTH'(DEAD_RST);
      actDiv <= DIV_WIDTH'(DIV_RST);
      actDead <= DEAD_WIDTH'(DEAD_RST);
      pending <= 1'b0;
      clockP <= 1'b0;
      clockN <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      clockP <= nextState == PH_P;
      clockN <= nextState == PH_N;
      running <= nextState != IDLE;
      pending <= !apply && (pending || wrEn);
      if (wrEn) begin
        shDiv <= wrDiv;
        shDead <= wrDead;
      end
      if (apply) begin
        actDiv <= newDiv;
        actDead <= newDead;
      end
    end
  end
endmodule

// File: rtl/ddr_clock_generator.sv
// ddr_clock_generator: CHANNELS independent non-overlapping clock pairs; ports Clock/ResetN, Enable, cfg (config bus slave), ClockP/ClockN/Running.
module ddr_clock_generator
  import ddr_clk_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DIV_WIDTH = 8,
  parameter int DEAD_WIDTH = 4
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic [CHANNELS-1:0] Enable,
  ddr_clock_generator_if.slave cfg,
  output logic [CHANNELS-1:0] ClockP,
  output logic [CHANNELS-1:0] ClockN,
  output logic [CHANNELS-1:0] Running
);
  localparam int CHAN_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int CW = maxWidth(DIV_WIDTH, DEAD_WIDTH);
  logic chanOk, cfgOk;
  // Div > Dead is the same as Div >= Dead+1 with Div >= 1, without the overflow of Dead+1.
  always_comb begin
    chanOk = 32'(cfg.CfgChan) < 32'(CHANNELS);
    cfgOk = chanOk && CW'(cfg.CfgDiv) > CW'(cfg.CfgDead);
    cfg.CfgReady = !(cfg.CfgValid && !chanOk);
    cfg.CfgError = ResetN && cfg.CfgValid && !cfgOk;
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    ddr_clock_channel #(
      .DIV_WIDTH(DIV_WIDTH),
      .DEAD_WIDTH(DEAD_WIDTH)
    ) uChan (
      .clock(Clock),
      .resetN(ResetN),
      .enable(Enable[i]),
      .wrEn(ResetN && cfg.CfgValid && cfgOk && cfg.CfgChan == CHAN_W'(i)),
      .wrDiv(cfg.CfgDiv),
      .wrDead(cfg.CfgDead),
      .clockP(ClockP[i]),
      .clockN(ClockN[i]),
      .running(Running[i])
    );
  end
endmodule

// File: tb/tb_ddr_clock_generator.sv
// tb_ddr_clock_generator: randomized self-checking bench against a period-pattern reference model.
module tb_ddr_clock_generator;
  localparam int CH = 3;
  localparam int DW = 8;
  localparam int EW = 4;
  localparam int CW = 2;
  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  logic [CH-1:0] Enable = '0;
  logic [CH-1:0] ClockP, ClockN, Running;
  int passed = 0;
  int total = 0;
  ddr_clock_generator_if #(.CHAN_W(CW), .DIV_WIDTH(DW), .DEAD_WIDTH(EW)) cfg();
  ddr_clock_generator #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEAD_WIDTH(EW)) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .Enable(Enable),
    .cfg(cfg.slave),
    .ClockP(ClockP),
    .ClockN(ClockN),
    .Running(Running)
  );
  always #5 Clock = ~Clock;
  // Reference: each started period is expanded into its full list of {P,N} output cycles.
  logic [1:0] pat[CH][$];
  int shDiv[CH], shDead[CH], actDiv[CH], actDead[CH];
  bit pend[CH];
  logic [CH-1:0] expP = '0, expN = '0, expR = '0;
  always @(posedge Clock) begin
    if (!ResetN) begin
      for (int c = 0; c < CH; c++) begin
        pat[c].delete();
        actDiv[c] = 2;
        actDead[c] = 0;
        pend[c] = 0;
      end
      expP = '0;
      expN = '0;
      expR = '0;
    end else begin
      if (cfg.CfgValid && int'(cfg.CfgChan) < CH && int'(cfg.CfgDiv) >= 1 && int'(cfg.CfgDiv) >= int'(cfg.CfgDead) + 1) begin
        shDiv[int'(cfg.CfgChan)] = int'(cfg.CfgDiv);
        shDead[int'(cfg.CfgChan)] = int'(cfg.CfgDead);
        pend[int'(cfg.CfgChan)] = 1;
      end
      for (int c = 0; c < CH; c++) begin
        if (pat[c].size() == 0 && Enable[c]) begin
          if (pend[c]) begin
            actDiv[c] = shDiv[c];
            actDead[c] = shDead[c];
            pend[c] = 0;
          end
          for (int k = 0; k < actDiv[c] - actDead[c]; k++) pat[c].push_back(2'b10);
          for (int k = 0; k < actDead[c]; k++) pat[c].push_back(2'b00);
          for (int k = 0; k < actDiv[c] - actDead[c]; k++) pat[c].push_back(2'b01);
          for (int k = 0; k < actDead[c]; k++) pat[c].push_back(2'b00);
        end
        if (pat[c].size() != 0) begin
          {expP[c], expN[c]} = pat[c].pop_front();
          expR[c] = 1'b1;
        end else begin
          {expP[c], expN[c]} = 2'b00;
          expR[c] = 1'b0;
        end
      end
    end
  end
  always @(negedge Clock) begin
    total++;
    if ((ClockP & ClockN) !== '0) $display("FAIL overlap got P=%b N=%b want P&N=0", ClockP, ClockN);
    else passed++;
  end
  task automatic tick();
    @(negedge Clock);
  endtask
  task automatic test_reset();
    ResetN = 1'b0;
    Enable = '0;
    cfg.CfgValid = 1'b0;
    cfg.CfgChan = '0;
    cfg.CfgDiv = '0;
    cfg.CfgDead = '0;
    repeat (2) tick();
    total++;
    if ({ClockP, ClockN, Running} !== '0) $display("FAIL reset_outputs got %b want 0", {ClockP, ClockN, Running});
    else passed++;
    total++;
    if ({cfg.CfgReady, cfg.CfgError} !== 2'b10) $display("FAIL reset_cfg got %b want 10", {cfg.CfgReady, cfg.CfgError});
    else passed++;
    ResetN = 1'b1;
  endtask
  task automatic test_default();
    logic [7:0] wantP = 8'b00110011;
    logic [7:0] wantN = 8'b11001100;
    Enable[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({ClockP[0], ClockN[0], Running[0]} !== {wantP[i], wantN[i], 1'b1}) $display("FAIL default_wave cycle %0d got %b want %b", i, {ClockP[0], ClockN[0], Running[0]}, {wantP[i], wantN[i], 1'b1});
      else passed++;
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL default_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
    end
  endtask
  task automatic test_config_running();
    int pc = 0, nc = 0;
    repeat ($urandom_range(0, 3)) tick();
    cfg.CfgValid = 1'b1;
    cfg.CfgChan = 2'd0;
    cfg.CfgDiv = 8'd5;
    cfg.CfgDead = 4'd1;
    #1;
    total++;
    if ({cfg.CfgReady, cfg.CfgError} !== 2'b10) $display("FAIL cfg_accept got %b want 10", {cfg.CfgReady, cfg.CfgError});
    else passed++;
    tick();
    cfg.CfgValid = 1'b0;
    total++;
    if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL cfg_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
    else passed++;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL cfg_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      pc += int'(ClockP[0]);
      nc += int'(ClockN[0]);
    end
    total++;
    if (pc != 4 || nc != 4) $display("FAIL cfg_period got P=%0d N=%0d want P=4 N=4", pc, nc);
    else passed++;
  endtask
  task automatic test_bad_config();
    int pc = 0;
    logic [CW-1:0] chans[3] = '{2'd0, 2'd3, 2'd1};
    logic [DW-1:0] divs[3] = '{8'd3, 8'd5, 8'd0};
    logic [EW-1:0] deads[3] = '{4'd3, 4'd1, 4'd0};
    logic [1:0] want[3] = '{2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      cfg.CfgValid = 1'b1;
      cfg.CfgChan = chans[i];
      cfg.CfgDiv = divs[i];
      cfg.CfgDead = deads[i];
      #1;
      total++;
      if ({cfg.CfgReady, cfg.CfgError} !== want[i]) $display("FAIL bad_cfg %0d got %b want %b", i, {cfg.CfgReady, cfg.CfgError}, want[i]);
      else passed++;
      tick();
    end
    cfg.CfgValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL bad_cfg_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      pc += int'(ClockP[0]);
    end
    total++;
    if (pc != 4) $display("FAIL bad_cfg_period got P=%0d want 4", pc);
    else passed++;
  endtask
  task automatic test_disable();
    bit low = 0, found = 0;
    int nc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!ClockP[0]) low = 1;
      else if (low) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) $display("FAIL disable_wait got timeout want ClockP rise");
    else passed++;
    tick();
    Enable[0] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      nc += int'(ClockN[0]);
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL disable_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
    end
    total++;
    if (Running[0] !== 1'b0 || nc != 4) $display("FAIL disable_end got run=%b nhigh=%0d want run=0 nhigh=4", Running[0], nc);
    else passed++;
  endtask
  task automatic test_two_channels();
    int d1 = $urandom_range(0, 6);
    int p0 = 0, p1 = 0;
    cfg.CfgValid = 1'b1;
    cfg.CfgChan = 2'd0;
    cfg.CfgDiv = 8'd2;
    cfg.CfgDead = 4'd0;
    tick();
    cfg.CfgChan = 2'd1;
    cfg.CfgDiv = 8'd7;
    cfg.CfgDead = EW'(d1);
    tick();
    cfg.CfgValid = 1'b0;
    Enable = 3'b011;
    for (int i = 0; i < 40; i++) begin
      tick();
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL two_ch_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
    end
    for (int i = 0; i < 28; i++) begin
      tick();
      p0 += int'(ClockP[0]);
      p1 += int'(ClockP[1]);
    end
    total++;
    if (p0 != 14 || p1 != 2 * (7 - d1)) $display("FAIL two_ch_period got p0=%0d p1=%0d want p0=14 p1=%0d", p0, p1, 2 * (7 - d1));
    else passed++;
  endtask
  task automatic test_random();
    logic [1:0] want;
    for (int i = 0; i < 500; i++) begin
      tick();
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL random_model cycle %0d got %b want %b", i, {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
      cfg.CfgValid = $urandom_range(0, 3) == 0;
      cfg.CfgChan = CW'($urandom_range(0, 3));
      cfg.CfgDiv = DW'($urandom_range(0, 15));
      cfg.CfgDead = EW'($urandom_range(0, 15));
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 15) == 0) Enable[c] = ~Enable[c];
      #1;
      want[1] = !(cfg.CfgValid && int'(cfg.CfgChan) >= CH);
      want[0] = cfg.CfgValid && !(int'(cfg.CfgChan) < CH && int'(cfg.CfgDiv) >= 1 && int'(cfg.CfgDiv) >= int'(cfg.CfgDead) + 1);
      total++;
      if ({cfg.CfgReady, cfg.CfgError} !== want) $display("FAIL random_cfg cycle %0d got %b want %b", i, {cfg.CfgReady, cfg.CfgError}, want);
      else passed++;
    end
    cfg.CfgValid = 1'b0;
  endtask
  task automatic test_reset_mid();
    bit found = 0;
    logic [7:0] wantP = 8'b00110011;
    logic [7:0] wantN = 8'b11001100;
    Enable = 3'b001;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (ClockN[0]) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) $display("FAIL reset_mid_wait got timeout want ClockN high");
    else passed++;
    ResetN = 1'b0;
    tick();
    total++;
    if ({ClockP, ClockN, Running} !== '0) $display("FAIL reset_mid got %b want 0", {ClockP, ClockN, Running});
    else passed++;
    ResetN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({ClockP[0], ClockN[0]} !== {wantP[i], wantN[i]}) $display("FAIL reset_mid_wave cycle %0d got %b want %b", i, {ClockP[0], ClockN[0]}, {wantP[i], wantN[i]});
      else passed++;
      total++;
      if ({ClockP, ClockN, Running} !== {expP, expN, expR}) $display("FAIL reset_mid_model got %b want %b", {ClockP, ClockN, Running}, {expP, expN, expR});
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_default();
    test_config_running();
    test_bad_config();
    test_disable();
    test_two_channels();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ddr_clock_generator.md
Name: ddr_clock_generator

Overview:
Parametrised successor to the single-pair crystal DDR oscillator. From one reference clock it generates CHANNELS independent complementary clock pairs (ClockP/ClockN). Each pair has a programmable half-period and a non-overlap dead time. Configuration changes are glitch-free: they apply only at period boundaries. Enable and disable are graceful. The block sits between the reference oscillator and the DDR consumers that need non-overlapping two-phase clocks.

Parameters:
CHANNELS, 2, number of independent output pairs (1..8)
DIV_WIDTH, 8, width of half-period count CfgDiv
DEAD_WIDTH, 4, width of dead-time count CfgDead
CHAN_W, $clog2(CHANNELS) min 1, width of CfgChan (derived, not overridable)

Ports:
Clock  in  1  reference clock; all logic is on its rising edge
ResetN  in  1  synchronous active-low reset
Enable  in  CHANNELS  per-channel run request
CfgValid  in  1  config write request
CfgReady  out  1  config accepted this cycle when CfgValid&CfgReady
CfgChan  in  CHAN_W  target channel
CfgDiv  in  DIV_WIDTH  half-period in Clock cycles
CfgDead  in  DEAD_WIDTH  dead-time in Clock cycles
CfgError  out  1  one-cycle pulse: rejected config
ClockP  out  CHANNELS  positive phase
ClockN  out  CHANNELS  negative phase
Running  out  CHANNELS  channel is in an active state

Behaviour:
- Reset: while ResetN=0 at a rising Clock edge, all outputs are 0 and every channel is in IDLE. Active div = 2, active dead = 0, shadow registers cleared, pending flags cleared. Reset asserted mid-period takes effect at the next edge; it forces ClockP=ClockN=0 without completing the period.
- Per-channel FSM: IDLE -> PH_P -> DEAD_PN -> PH_N -> DEAD_NP -> PH_P...
  - PH_P: ClockP=1 for (Div-Dead) cycles.
  - DEAD_PN: both 0 for Dead cycles; skipped when Dead=0.
  - PH_N: ClockN=1 for (Div-Dead) cycles.
  - DEAD_NP: both 0 for Dead cycles; skipped when Dead=0.
  - Period = 2*Div cycles exactly.
- Invariant: ClockP & ClockN = 0 in every cycle, every channel, including config change and reset.
- Outputs are registered. ClockP rises the cycle after the first edge that samples Enable=1 in IDLE.
- Running=1 in every non-IDLE state.
- Disable: when Enable drops, the channel completes the current period. It goes to IDLE from the end of DEAD_NP, or from the end of PH_N when Dead=0. No truncated pulses. If Enable returns before the period ends, the channel continues without interruption.
- Config: CfgReady is always 1 except in the cycle of a CfgValid with CfgChan >= CHANNELS, where it is 0.
  - Accepted only if CfgDiv >= CfgDead+1 and CfgDiv >= 1. Otherwise CfgError pulses for 1 cycle and shadow/active values are unchanged.
  - CfgChan >= CHANNELS also pulses CfgError.
  - An accepted write goes to that channel's shadow register and sets pending. A later write before application overwrites the shadow (last-wins).
  - The shadow is copied to active at the transition into PH_P: from IDLE, or from DEAD_NP (or from PH_N when Dead=0). Pending clears there. No mid-period change.
- Counter: one down-counter per channel, width max(DIV_WIDTH,DEAD_WIDTH). It loads on state entry and the state exits when the count reaches 1.
- Channels are fully independent. A simultaneous config write and Enable edge on the same channel applies the new config to the first period.

Decomposition:
- Shared package ddr_clk_pkg holds:
  - the state enum (IDLE, PH_P, DEAD_PN, PH_N, DEAD_NP);
  - the reset constants (DIV_RST=2, DEAD_RST=0).
- Sub-module ddr_clock_channel contains one FSM, counter, shadow/active registers and output flops. The top level holds config decode/validation and a generate loop over CHANNELS.

Test Plan:
- Reset, then Enable[0]=1 with defaults -> ClockP[0],ClockN[0] toggle every 2 cycles, period 4, never both 1; Running[0]=1.
- Config ch0 Div=5 Dead=1 while running -> the current period finishes on the old value. Next period: ClockP high 4, dead 1, ClockN high 4, dead 1 (period 10).
- Config Div=3 Dead=3 -> CfgError pulse, period unchanged. Config CfgChan=2 with CHANNELS=2 -> CfgError and CfgReady=0 that cycle.
- Drop Enable[0] mid-PH_P with Div=5 Dead=1 -> remaining PH_P, DEAD_PN, PH_N and DEAD_NP all complete, then IDLE and Running=0. No pulse shorter than 4.
- Two channels with Div 2 and Div 7, both enabled -> independent periods 4 and 14. Overlap checker asserts ClockP&ClockN==0 every cycle.
- ResetN=0 in the middle of PH_N -> next edge: all outputs 0, Running 0. After release, the period is back to the default of 4.
